// File: rtl/ea_status_rd_if.sv
// Host bus bundle for the EA4163 status responder: read/write strobes,
// write data, and the registered read data, drive enable and interrupt.
interface ea_status_rd_if;
    localparam int unsigned DATA_W = 16;

    logic              rd7C94;
    logic              wr7C9A;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_oe;
    logic              irq;

    modport master (
        output rd7C94, wr7C9A, wdata,
        input  rdata, rdata_oe, irq
    );

    modport slave (
        input  rd7C94, wr7C9A, wdata,
        output rdata, rdata_oe, irq
    );
endinterface

// File: rtl/ea_status_rd.sv
// ea_status_rd: host-read status responder for status address 0x7C94.
// Snapshots live flags, sticky event latches, irq and a frame counter into a
// 16-bit word on the rising edge of the read strobe, holds it for the whole
// read, and clears the sticky latches when the strobe falls.
// Optional feature macro: EASTAT_FRAMECNT_EN (8-bit frame counter in [15:8]).
module ea_status_rd #(
    parameter logic [3:0] STATUS_ID = 4'h0
) (
    input  logic          clk,
    input  logic          reset,
    ea_status_rd_if.slave host,
    input  logic          eareset,
    input  logic          outchen,
    input  logic          inchen,
    input  logic          outfifo_empty,
    input  logic          infifo_full,
    input  logic          underrun,
    input  logic          overrun,
    input  logic          frame_done
);
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned STICKY_W = 3;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                rd_q;
    logic [STICKY_W-1:0] sticky;
    logic [STICKY_W-1:0] mask;
    logic                irq_q;
    logic [DATA_W-1:0]   snap_q;
    logic                oe_q;
    logic [CNT_W-1:0]    frame_cnt;
    logic                rise;
    logic                fall;
    logic                snap_load;
    logic                sticky_clr;
    logic [DATA_W-1:0]   status_c;
    logic [STICKY_W-1:0] events;

    assign rise   = host.rd7C94 & ~rd_q;
    assign fall   = ~host.rd7C94 & rd_q;
    assign events = {frame_done, overrun, underrun};

    // Live status word as it would be captured this cycle
    assign status_c = {frame_cnt, irq_q, sticky, infifo_full, outfifo_empty, inchen, outchen};

    // Read sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read sequencer next state and capture/clear controls
    always_comb begin
        state_nxt  = state;
        snap_load  = 1'b0;
        sticky_clr = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = ACTIVE;
                    snap_load = 1'b1;
                end
            end
            ACTIVE: begin
                if (fall) begin
                    state_nxt  = IDLE;
                    sticky_clr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (eareset) begin
            state_nxt  = IDLE;
            snap_load  = 1'b0;
            sticky_clr = 1'b0;
        end
    end

    // Strobe history for edge detection; follows the strobe even across soft reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= host.rd7C94;
        end
    end

    // Sticky latches: a new event wins over a read-completion clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky <= '0;
        end else if (eareset) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky_clr ? STICKY_W'(0) : sticky) | events;
        end
    end

    // IRQ mask register and registered interrupt request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask  <= '0;
            irq_q <= 1'b0;
        end else if (eareset) begin
            mask  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (host.wr7C9A) begin
                mask <= host.wdata[6:4];
            end
            irq_q <= |(sticky & mask);
        end
    end

    // Snapshot and bus drive enable, held stable for the whole read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
            oe_q   <= 1'b0;
        end else if (eareset) begin
            snap_q <= '0;
            oe_q   <= 1'b0;
        end else if (snap_load) begin
            snap_q <= status_c;
            oe_q   <= 1'b1;
        end else if (sticky_clr) begin
            oe_q   <= 1'b0;
        end
    end

`ifdef EASTAT_FRAMECNT_EN
    // Free-running frame counter, wraps, untouched by reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (eareset) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end
`else
    assign frame_cnt = '0;
`endif

    assign host.rdata    = snap_q;
    assign host.rdata_oe = oe_q;
    assign host.irq      = irq_q;

    // Write-data bits outside the mask field and the reserved ID carry no function
    logic unused_ok;
    assign unused_ok = ^{host.wdata[15:7], host.wdata[3:0], STATUS_ID};

endmodule

// File: tb/tb_ea_status_rd.sv
// Self-checking bench for ea_status_rd: directed scenarios with fixed
// expected words, then randomized traffic against a transaction-level model.
module tb_ea_status_rd;
    logic clk = 1'b0;
    logic reset;
    logic eareset, outchen, inchen, outfifo_empty, infifo_full;
    logic underrun, overrun, frame_done;

    ea_status_rd_if bus();

    ea_status_rd #(.STATUS_ID(4'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .host          (bus),
        .eareset       (eareset),
        .outchen       (outchen),
        .inchen        (inchen),
        .outfifo_empty (outfifo_empty),
        .infifo_full   (infifo_full),
        .underrun      (underrun),
        .overrun       (overrun),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

`ifdef EASTAT_FRAMECNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: read transactions, event latches, total frames seen
    bit          m_rd_prev;
    bit          m_in_read;
    bit          m_oe;
    bit          m_irq;
    bit [2:0]    m_sticky;
    bit [2:0]    m_mask;
    int          m_frames;
    logic [15:0] m_snap;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_rd_prev = 1'b0;
        m_in_read = 1'b0;
        m_oe      = 1'b0;
        m_irq     = 1'b0;
        m_sticky  = 3'b000;
        m_mask    = 3'b000;
        m_frames  = 0;
        m_snap    = 16'h0000;
    endfunction

    function automatic logic [15:0] model_status();
        int shown;
        int word;
        shown = CNT_EN ? (m_frames % 256) : 0;
        word  = shown * 256 + int'(m_irq) * 128 + int'(m_sticky) * 16
              + int'(infifo_full) * 8 + int'(outfifo_empty) * 4
              + int'(inchen) * 2 + int'(outchen);
        return 16'(word);
    endfunction

    // One clock of the model, evaluated with the inputs present at the edge
    function automatic void model_step();
        bit       rise;
        bit       fall;
        bit       next_irq;
        bit [2:0] ev;
        rise     = bus.rd7C94 && !m_rd_prev;
        fall     = !bus.rd7C94 && m_rd_prev;
        ev       = {frame_done, overrun, underrun};
        next_irq = (m_sticky & m_mask) != 3'b000;
        if (eareset) begin
            m_sticky  = 3'b000;
            m_frames  = 0;
            m_mask    = 3'b000;
            m_snap    = 16'h0000;
            m_oe      = 1'b0;
            m_irq     = 1'b0;
            m_in_read = 1'b0;
        end else begin
            if (rise && !m_in_read) begin
                m_snap    = model_status();
                m_oe      = 1'b1;
                m_in_read = 1'b1;
            end else if (fall && m_in_read) begin
                m_oe      = 1'b0;
                m_in_read = 1'b0;
                m_sticky  = 3'b000;
            end
            m_sticky = m_sticky | ev;
            if (frame_done) m_frames = m_frames + 1;
            if (bus.wr7C9A) m_mask = bus.wdata[6:4];
            m_irq = next_irq;
        end
        m_rd_prev = bus.rd7C94;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_rdata", bus.rdata, m_snap);
        check("model_oe", 16'(bus.rdata_oe), 16'(m_oe));
        check("model_irq", 16'(bus.irq), 16'(m_irq));
    endtask

    task automatic read_strobe_end();
        bus.rd7C94 = 1'b0;
        tick();
        tick();
    endtask

    logic [15:0] base;
    int          run_left;

    initial begin
        reset = 1'b1;
        eareset = 1'b0; outchen = 1'b0; inchen = 1'b0;
        outfifo_empty = 1'b0; infifo_full = 1'b0;
        underrun = 1'b0; overrun = 1'b0; frame_done = 1'b0;
        bus.rd7C94 = 1'b0; bus.wr7C9A = 1'b0; bus.wdata = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_rdata", bus.rdata, 16'h0000);
        check("reset_oe", 16'(bus.rdata_oe), 16'h0000);
        check("reset_irq", 16'(bus.irq), 16'h0000);
        reset = 1'b0;

        // Live flags only
        outchen = 1'b1; outfifo_empty = 1'b1;
        bus.rd7C94 = 1'b1;
        tick();
        check("live_rdata", bus.rdata, 16'h0005);
        check("live_oe", 16'(bus.rdata_oe), 16'h0001);
        tick();
        bus.rd7C94 = 1'b0;
        tick();
        check("live_oe_drop", 16'(bus.rdata_oe), 16'h0000);
        outchen = 1'b0; outfifo_empty = 1'b0;

        // Overrun with mask bit 1 enabled
        overrun = 1'b1; tick(); overrun = 1'b0;
        bus.wr7C9A = 1'b1; bus.wdata = 16'h0020; tick(); bus.wr7C9A = 1'b0;
        tick();
        check("ovr_irq_set", 16'(bus.irq), 16'h0001);
        bus.rd7C94 = 1'b1; tick();
        check("ovr_rdata", bus.rdata, 16'h00A0);
        tick();
        bus.rd7C94 = 1'b0; tick();
        check("ovr_oe_drop", 16'(bus.rdata_oe), 16'h0000);
        check("ovr_irq_hold", 16'(bus.irq), 16'h0001);
        tick();
        check("ovr_irq_drop", 16'(bus.irq), 16'h0000);
        bus.rd7C94 = 1'b1; tick();
        check("ovr_reread", bus.rdata, 16'h0000);
        tick();
        read_strobe_end();

        // Underrun in the exact cycle of the strobe fall survives the clear
        bus.rd7C94 = 1'b1; tick(); tick();
        bus.rd7C94 = 1'b0; underrun = 1'b1; tick(); underrun = 1'b0;
        tick();
        bus.rd7C94 = 1'b1; tick();
        check("setwins_rdata", bus.rdata, 16'h0010);
        tick();
        read_strobe_end();

        // 257 frames: counter wraps to 0x01
        frame_done = 1'b1;
        for (int i = 0; i < 257; i++) tick();
        frame_done = 1'b0;
        tick();
        bus.rd7C94 = 1'b1; tick();
        check("frame_rdata", bus.rdata, CNT_EN ? 16'h0140 : 16'h0040);
        tick();
        read_strobe_end();

        // Event during a read does not disturb the snapshot
        base = CNT_EN ? 16'h0100 : 16'h0000;
        bus.rd7C94 = 1'b1; tick();
        check("active_rdata0", bus.rdata, base);
        tick();
        check("active_rdata1", bus.rdata, base);
        bus.rd7C94 = 1'b0; overrun = 1'b1; tick(); overrun = 1'b0;
        check("active_rdata_end", bus.rdata, base);
        check("active_oe_end", 16'(bus.rdata_oe), 16'h0000);
        tick();
        bus.rd7C94 = 1'b1; tick();
        check("active_next_read", bus.rdata, base | 16'h00A0);
        tick();
        read_strobe_end();

        // Soft reset during a read with every sticky bit set
        underrun = 1'b1; overrun = 1'b1; frame_done = 1'b1; tick();
        underrun = 1'b0; overrun = 1'b0; frame_done = 1'b0;
        bus.wr7C9A = 1'b1; bus.wdata = 16'h0070; tick(); bus.wr7C9A = 1'b0;
        tick();
        bus.rd7C94 = 1'b1; tick();
        check("ea_pre_rdata", bus.rdata, (CNT_EN ? 16'h0200 : 16'h0000) | 16'h00F0);
        tick();
        eareset = 1'b1; tick(); eareset = 1'b0;
        check("ea_rdata", bus.rdata, 16'h0000);
        check("ea_oe", 16'(bus.rdata_oe), 16'h0000);
        check("ea_irq", 16'(bus.irq), 16'h0000);
        bus.rd7C94 = 1'b0; tick(); tick();
        overrun = 1'b1; tick(); overrun = 1'b0;
        tick(); tick();
        check("ea_mask_cleared", 16'(bus.irq), 16'h0000);
        bus.rd7C94 = 1'b1; tick();
        check("ea_cnt_cleared", bus.rdata, 16'h0020);
        tick();
        read_strobe_end();

        // Asynchronous reset in the middle of a read
        outchen = 1'b1; inchen = 1'b1;
        bus.rd7C94 = 1'b1; tick();
        check("async_pre_rdata", bus.rdata, 16'h0003);
        tick();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rdata", bus.rdata, 16'h0000);
        check("async_oe", 16'(bus.rdata_oe), 16'h0000);
        check("async_irq", 16'(bus.irq), 16'h0000);
        model_reset();
        bus.rd7C94 = 1'b0; outchen = 1'b0; inchen = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Randomized traffic against the model
        run_left = 3;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                bus.rd7C94 = ~bus.rd7C94;
                run_left   = int'($urandom_range(2, 6));
            end
            run_left--;
            outchen       = 1'($urandom_range(0, 1));
            inchen        = 1'($urandom_range(0, 1));
            outfifo_empty = 1'($urandom_range(0, 1));
            infifo_full   = 1'($urandom_range(0, 1));
            underrun      = ($urandom_range(0, 5) == 0);
            overrun       = ($urandom_range(0, 5) == 0);
            frame_done    = ($urandom_range(0, 3) == 0);
            eareset       = ($urandom_range(0, 79) == 0);
            bus.wr7C9A    = ($urandom_range(0, 9) == 0);
            bus.wdata     = 16'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ea_status_rd.md
# ea_status_rd

Host-read status responder for the EA4163 card; the read-side counterpart of the command decoder that handles host writes. It snapshots channel-enable state, FIFO flags, sticky error/event latches and a frame counter into a 16-bit status word. It drives that word onto the host data bus during a read of status address 0x7C94. Sticky bits clear on completion of the read, and a maskable interrupt request is raised from them.

## Interface
Parameters:
- STATUS_ID, 4'h0: reserved; not reflected in the status word.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- rd7C94  input  1  host read strobe for status address, level, synchronous to clk, ≥2 cycles wide
- wr7C9A  input  1  host write strobe for IRQ-mask address, single-cycle qualified
- wdata  input  16  host write data
- eareset  input  1  soft reset from command decoder, single cycle
- outchen  input  1  output channel enable (live)
- inchen  input  1  input channel enable (live)
- outfifo_empty  input  1  output FIFO empty flag (live)
- infifo_full  input  1  input FIFO full flag (live)
- underrun  input  1  output underrun event pulse
- overrun  input  1  input overrun event pulse
- frame_done  input  1  frame-complete event pulse
- rdata  output  16  status snapshot
- rdata_oe  output  1  bus drive enable for rdata
- irq  output  1  interrupt request, active-high

## Operation
- Status word: [0] outchen; [1] inchen; [2] outfifo_empty; [3] infifo_full.
- Status word: [4] underrun sticky; [5] overrun sticky; [6] frame_done sticky; [7] irq.
- Status word: [15:8] frame counter.
- Sticky bits: set by the event pulse, held until cleared.
- Set beats clear: an event in the same cycle as a clear leaves the bit set.
- Frame counter: 8-bit, increments on each frame_done, wraps 0xFF→0x00, never saturates.
- IRQ mask: 3-bit register, mask[2:0] <= wdata[6:4] on wr7C9A.
- irq = |(sticky[6:4] & mask[2:0]), registered.
- Read sequencer, states IDLE → ACTIVE → IDLE:
  - rd_q tracks rd7C94.
  - Rise (rd7C94 & ~rd_q): snapshot register <= current status word (irq bit = current irq); rdata_oe <= 1; enter ACTIVE.
  - Fall (~rd7C94 & rd_q): rdata_oe <= 0; all sticky bits clear (subject to set-beats-clear); enter IDLE.
  - Frame counter is not cleared by a read.
- Snapshot is stable for the whole of ACTIVE; events during ACTIVE update the sticky bits only, not rdata.
- eareset: same-cycle clear of sticky bits, frame counter, mask, snapshot and rdata_oe; sequencer to IDLE.
- An event pulse in the eareset cycle is discarded.
- wr7C9A in the same cycle as eareset: eareset wins, mask = 0.

## Timing
- Reset values: rdata = 0x0000, rdata_oe = 0, irq = 0.
- Reset values of internal state: sticky = 0, counter = 0x00, mask = 0, rd_q = 0, state IDLE.
- Reset mid-read: rdata_oe drops asynchronously; no sticky clear is performed beyond the reset itself.
- rdata and rdata_oe are valid 1 clk after rd7C94 rises.
- rdata_oe deasserts 1 clk after rd7C94 falls.
- Event pulse → sticky bit visible internally next cycle; irq asserts 2 cycles after the pulse if unmasked.
- After a read ends, irq drops 2 cycles after the rd7C94 fall, unless a new masked-in event arrived.
- Mask write takes effect on irq 2 cycles after wr7C9A.
- Strobes shorter than 2 clk are unsupported.

## Configuration
- Macro EASTAT_FRAMECNT_EN.
- Defined: 8-bit frame counter implemented and reported in rdata[15:8].
- Undefined: no counter flops; rdata[15:8] reads 0x00; frame_done still sets sticky bit 6.

## Test plan
- Reset, then read with outchen=1, inchen=0, outfifo_empty=1 → rdata = 0x0005, rdata_oe high 1 clk after strobe.
- overrun pulse, mask = 3'b010 written via wdata = 0x0020 → irq high; read → rdata = 0x00A0; irq low 2 clk after strobe falls; second read → 0x0000.
- underrun pulse in the exact cycle of the strobe fall → bit 4 stays set; next read shows 0x0010.
- 257 frame_done pulses then read → rdata[15:8] = 0x01, bit 6 set; with the macro undefined → [15:8] = 0x00.
- Event during ACTIVE → rdata unchanged until the strobe ends; the following read shows the event.
- eareset during ACTIVE with all sticky bits set → rdata_oe, rdata, irq, counter, mask all 0 next cycle; asynchronous reset mid-read → outputs 0 immediately.
